// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock controller: mode encodings,
// two-digit BCD fields and the BCD increment helper.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    AL_HR   = 3'd3,
    AL_MIN  = 3'd4
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [3:0] DIG_BLANK     = 4'hF;
  localparam bcd2_t      BCD_ZERO      = 8'h00;
  localparam bcd2_t      HR_MAX        = 8'h23;
  localparam bcd2_t      MS_MAX        = 8'h59;
  localparam bcd2_t      ALARM_HR_RST  = 8'h06;
  localparam bcd2_t      ALARM_MIN_RST = 8'h00;

  // Wraps to 00 after max_v; ones roll into tens at 9.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max_v);
    bcd2_t r;
    if (v == max_v) begin
      r = BCD_ZERO;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Front-panel inputs and display/alarm outputs of the clock controller.
interface clock_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       alarm_en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [3:0] hr_ones;
  logic [3:0] hr_tens;
  logic [2:0] mode;
  logic       alarm_active;

  modport master (
    output btn_mode, btn_inc, alarm_en,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, mode, alarm_active
  );

  modport slave (
    input  btn_mode, btn_inc, alarm_en,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, mode, alarm_active
  );
endinterface

// File: rtl/tick_gen.sv
// Seconds tick and display blink phase. The next blink phase is exported so the
// registered display can track the phase without an extra cycle of lag.
module tick_gen #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BLINK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic blink_rst_i,
  output logic sec_tick_o,
  output logic blink_hide_nxt_o
);
  localparam int HALF = CLK_HZ / (2 * BLINK_DIV);
  localparam int TW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int BW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          hide_q, hide_d;

  assign sec_tick_o       = (tick_q == TICK_LAST);
  assign blink_hide_nxt_o = hide_d;

  always_comb begin
    tick_d      = sec_tick_o ? '0 : tick_q + TW'(1);
    blink_cnt_d = blink_cnt_q + BW'(1);
    hide_d      = hide_q;
    if (blink_rst_i) begin
      blink_cnt_d = '0;
      hide_d      = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      hide_d      = ~hide_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q      <= '0;
      blink_cnt_q <= '0;
      hide_q      <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      hide_q      <= hide_d;
    end
  end
endmodule

// File: rtl/clock_ctrl.sv
// Alarm clock timekeeping, set-mode FSM, alarm compare and display digit mux.
//   state   | meaning
//   RUN     | time runs, alarm armed, display hh:mm:ss
//   SET_HR  | time frozen, inc edits hours (blinking)
//   SET_MIN | time frozen, inc edits minutes (blinking); exit clears seconds
//   AL_HR   | time runs, display alarm hh:mm, inc edits alarm hours
//   AL_MIN  | time runs, display alarm hh:mm, inc edits alarm minutes
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BLINK_DIV  = 2,
  parameter int ALARM_SECS = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  clock_ctrl_if.slave  bus
);
  localparam int AW = (ALARM_SECS > 2) ? $clog2(ALARM_SECS) : 1;

  mode_e         state_q, state_d;
  bcd2_t         hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  bcd2_t         al_hr_q, al_hr_d, al_min_q, al_min_d;
  logic          al_act_q, al_act_d;
  logic [AW-1:0] al_cnt_q, al_cnt_d;
  logic [1:0]    mode_sh_q, inc_sh_q;
  logic [23:0]   disp_q, disp_d;
  logic          sec_tick, hide_nxt, blink_rst;
  logic          mode_press, inc_press, ack, mode_ev, inc_ev, time_runs;

  tick_gen #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) u_tick (
    .clk              (clk),
    .rst_n            (rst_n),
    .blink_rst_i      (blink_rst),
    .sec_tick_o       (sec_tick),
    .blink_hide_nxt_o (hide_nxt)
  );

  // A press that silences the alarm is consumed; mode beats a same-cycle inc.
  assign mode_press = mode_sh_q[0] & ~mode_sh_q[1];
  assign inc_press  = inc_sh_q[0] & ~inc_sh_q[1];
  assign ack        = al_act_q & (mode_press | inc_press);
  assign mode_ev    = mode_press & ~ack;
  assign inc_ev     = inc_press & ~mode_press & ~al_act_q;
  assign blink_rst  = inc_ev & (state_q != RUN);
  assign time_runs  = sec_tick & (state_q != SET_HR) & (state_q != SET_MIN);

  always_comb begin
    state_d  = state_q;
    hr_d     = hr_q;
    min_d    = min_q;
    sec_d    = sec_q;
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    al_act_d = al_act_q;
    al_cnt_d = al_cnt_q;

    if (time_runs) begin
      sec_d = bcd_inc(sec_q, MS_MAX);
      if (sec_q == MS_MAX) begin
        min_d = bcd_inc(min_q, MS_MAX);
        if (min_q == MS_MAX) hr_d = bcd_inc(hr_q, HR_MAX);
      end
    end

    case (state_q)
      RUN:     if (mode_ev) state_d = SET_HR;
      SET_HR:  if (mode_ev) state_d = SET_MIN;
               else if (inc_ev) hr_d = bcd_inc(hr_q, HR_MAX);
      SET_MIN: if (mode_ev) begin
                 state_d = AL_HR;
                 sec_d   = BCD_ZERO;
               end else if (inc_ev) begin
                 min_d = bcd_inc(min_q, MS_MAX);
               end
      AL_HR:   if (mode_ev) state_d = AL_MIN;
               else if (inc_ev) al_hr_d = bcd_inc(al_hr_q, HR_MAX);
      AL_MIN:  if (mode_ev) state_d = RUN;
               else if (inc_ev) al_min_d = bcd_inc(al_min_q, MS_MAX);
      default: state_d = RUN;
    endcase

    if (!bus.alarm_en || ack) begin
      al_act_d = 1'b0;
    end else if (al_act_q) begin
      if (sec_tick) begin
        if (al_cnt_q == '0) al_act_d = 1'b0;
        else                al_cnt_d = al_cnt_q - AW'(1);
      end
    end else if (state_q == RUN && sec_tick && !mode_ev &&
                 {hr_d, min_d, sec_d} == {al_hr_q, al_min_q, BCD_ZERO}) begin
      al_act_d = 1'b1;
      al_cnt_d = AW'(ALARM_SECS - 1);
    end

    // Built from next-state values so the display lands with the state change.
    disp_d = {hr_d, min_d, sec_d};
    case (state_d)
      SET_HR:  if (hide_nxt) disp_d[23:16] = {DIG_BLANK, DIG_BLANK};
      SET_MIN: if (hide_nxt) disp_d[15:8]  = {DIG_BLANK, DIG_BLANK};
      AL_HR: begin
        disp_d = {al_hr_d, al_min_d, DIG_BLANK, DIG_BLANK};
        if (hide_nxt) disp_d[23:16] = {DIG_BLANK, DIG_BLANK};
      end
      AL_MIN: begin
        disp_d = {al_hr_d, al_min_d, DIG_BLANK, DIG_BLANK};
        if (hide_nxt) disp_d[15:8] = {DIG_BLANK, DIG_BLANK};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      hr_q      <= BCD_ZERO;
      min_q     <= BCD_ZERO;
      sec_q     <= BCD_ZERO;
      al_hr_q   <= ALARM_HR_RST;
      al_min_q  <= ALARM_MIN_RST;
      al_act_q  <= 1'b0;
      al_cnt_q  <= '0;
      disp_q    <= '0;
      // Seeded with the live level so a button held through reset is not a press.
      mode_sh_q <= {2{bus.btn_mode}};
      inc_sh_q  <= {2{bus.btn_inc}};
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      al_hr_q   <= al_hr_d;
      al_min_q  <= al_min_d;
      al_act_q  <= al_act_d;
      al_cnt_q  <= al_cnt_d;
      disp_q    <= disp_d;
      mode_sh_q <= {mode_sh_q[0], bus.btn_mode};
      inc_sh_q  <= {inc_sh_q[0], bus.btn_inc};
    end
  end

  assign {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = disp_q;
  assign bus.mode         = state_q;
  assign bus.alarm_active = al_act_q;
endmodule
